// File: rtl/axi_lite_burst_master.sv
// AXI4 INCR burst initiator: one outstanding command, one completion per command.
// Optional address range check enabled by defining AXI_MST_ADDR_CHECK_EN.
module axi_lite_burst_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 6,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_2000,
  parameter logic [ADDR_W-1:0] END_ADDR  = 32'h0000_2FFF
) (
  input  logic                clk,
  input  logic                rstn,
  // command / data streams
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ID_W-1:0]     cmd_id,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [7:0]          cmd_len,
  input  logic                wd_valid,
  output logic                wd_ready,
  input  logic [DATA_W-1:0]   wd_data,
  input  logic [DATA_W/8-1:0] wd_strb,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_last,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [1:0]          rsp_resp,
  output logic                rsp_err,
  // AXI4 write address
  output logic [ID_W-1:0]     awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic [3:0]          awqos,
  output logic [3:0]          awregion,
  output logic                awvalid,
  input  logic                awready,
  // AXI4 write data / response
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_W-1:0]     bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  // AXI4 read address / data
  output logic [ID_W-1:0]     arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic [3:0]          arqos,
  output logic [3:0]          arregion,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_W-1:0]     rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready
);

  localparam logic [2:0] SIZE = 3'b010;
  localparam logic [1:0] INCR = 2'b01;

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_RSP} state_t;

  state_t            state, state_nx;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [7:0]        cnt_q;
  logic              wr_q;
  logic [1:0]        resp_q;
  logic              err_q;
  logic              accept, reject, last_cnt, w_fire, r_fire;

  assign accept   = cmd_valid && cmd_ready;
  assign last_cnt = (cnt_q == len_q);
  assign w_fire   = wvalid && wready;
  assign r_fire   = rvalid && rready;

`ifdef AXI_MST_ADDR_CHECK_EN
  // Last byte of the burst is addr + 4*len + 3; one extra bit keeps the sum from wrapping.
  localparam logic [ADDR_W:0] THREE = 3;
  logic [ADDR_W:0] last_byte;
  assign last_byte = {1'b0, cmd_addr} + {{(ADDR_W-9){1'b0}}, cmd_len, 2'b00} + THREE;
  assign reject    = (cmd_addr < BASE_ADDR) || (last_byte > {1'b0, END_ADDR});
`else
  logic unused_cfg;
  assign unused_cfg = ^{BASE_ADDR, END_ADDR};
  assign reject     = 1'b0;
`endif

  // Severity order DECERR > SLVERR > EXOKAY > OKAY matches the numeric encoding.
  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (accept) state_nx = reject ? S_RSP : (cmd_write ? S_AW : S_AR);
      S_AW:   if (awready) state_nx = S_W;
      S_W:    if (w_fire && last_cnt) state_nx = S_B;
      S_B:    if (bvalid) state_nx = S_RSP;
      S_AR:   if (arready) state_nx = S_R;
      // exit on whichever of rlast / final count comes first
      S_R:    if (r_fire && (rlast || last_cnt)) state_nx = S_RSP;
      S_RSP:  if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == S_IDLE) && rstn;
    awvalid   = (state == S_AW);
    awsize    = (state == S_AW) ? SIZE : 3'b000;
    awburst   = (state == S_AW) ? INCR : 2'b00;
    arvalid   = (state == S_AR);
    arsize    = (state == S_AR) ? SIZE : 3'b000;
    arburst   = (state == S_AR) ? INCR : 2'b00;
    wvalid    = 1'b0;
    wd_ready  = 1'b0;
    wdata     = '0;
    wstrb     = '0;
    wlast     = 1'b0;
    bready    = (state == S_B);
    rready    = 1'b0;
    rd_valid  = 1'b0;
    rd_data   = '0;
    rd_last   = 1'b0;
    rsp_valid = (state == S_RSP);
    rsp_write = 1'b0;
    rsp_resp  = 2'b00;
    rsp_err   = 1'b0;
    if (state == S_W) begin
      wvalid   = wd_valid;
      wd_ready = wready;
      wdata    = wd_data;
      wstrb    = wd_strb;
      wlast    = last_cnt;
    end
    if (state == S_R) begin
      rready   = rd_ready;
      rd_valid = rvalid;
      rd_data  = rdata;
      rd_last  = rlast;
    end
    if (state == S_RSP) begin
      rsp_write = wr_q;
      rsp_resp  = resp_q;
      rsp_err   = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      id_q   <= '0;
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      wr_q   <= 1'b0;
      resp_q <= 2'b00;
      err_q  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (accept) begin
          id_q   <= cmd_id;
          addr_q <= cmd_addr;
          len_q  <= cmd_len;
          wr_q   <= cmd_write;
          cnt_q  <= '0;
          resp_q <= reject ? 2'b11 : 2'b00;
          err_q  <= 1'b0;
        end
        S_W: if (w_fire) cnt_q <= cnt_q + 8'd1;
        S_B: if (bvalid) begin
          resp_q <= worst(resp_q, bresp);
          err_q  <= err_q | (bid != id_q);
        end
        S_R: if (r_fire) begin
          cnt_q  <= cnt_q + 8'd1;
          resp_q <= worst(resp_q, rresp);
          err_q  <= err_q | (rid != id_q) | (rlast != last_cnt);
        end
        default: ;
      endcase
    end
  end

  assign awid     = id_q;
  assign awaddr   = addr_q;
  assign awlen    = len_q;
  assign awlock   = 1'b0;
  assign awcache  = 4'b0000;
  assign awprot   = 3'b000;
  assign awqos    = 4'b0000;
  assign awregion = 4'b0000;
  assign arid     = id_q;
  assign araddr   = addr_q;
  assign arlen    = len_q;
  assign arlock   = 1'b0;
  assign arcache  = 4'b0000;
  assign arprot   = 3'b000;
  assign arqos    = 4'b0000;
  assign arregion = 4'b0000;

endmodule

// File: tb/tb_axi_lite_burst_master.sv
// Directed bench for axi_lite_burst_master: table of burst commands against a
// procedural AXI slave, plus hand sequences for latency, reset and stalls.
module tb_axi_lite_burst_master;
  localparam int ADDR_W = 32, DATA_W = 32, ID_W = 6;

  logic clk = 1'b0, rstn;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [ID_W-1:0] cmd_id;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0] cmd_len;
  logic wd_valid, wd_ready, rd_valid, rd_ready, rd_last;
  logic [DATA_W-1:0] wd_data, rd_data;
  logic [3:0] wd_strb;
  logic rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [1:0] rsp_resp;
  logic [ID_W-1:0] awid, arid, bid, rid;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awlock, arlock;
  logic [3:0] awcache, arcache, awqos, arqos, awregion, arregion, wstrb;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [DATA_W-1:0] wdata, rdata;

  axi_lite_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_id(cmd_id),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_resp(rsp_resp),
    .rsp_err(rsp_err),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos), .awregion(awregion),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arqos(arqos), .arregion(arregion),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit wr; int id; logic [31:0] addr; int len;
    int inj_beat; int inj_resp; int inj_id; int rlast_at;
    int aw_wait; bit wtoggle; int rd_wait; int rsp_wait;
    int exp_beats; int exp_resp; bit exp_err;
  } vec_t;

  int errors = 0, checks = 0, cur = -1;
  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL vec%0d %s: got %0h want %0h", cur, nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pat(input int k);
    return 32'hDEADBEEF + 32'h01010101 * 32'(k);
  endfunction

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_id = '0; cmd_addr = '0; cmd_len = '0;
    wd_valid = 0; wd_data = '0; wd_strb = '0; rd_ready = 0; rsp_ready = 0;
    awready = 0; wready = 0; bid = '0; bresp = '0; bvalid = 0; arready = 0;
    rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
  endtask

  task automatic run_vec(input vec_t v);
    int wbeat = 0, rbeat = 0, axn = 0, axw = 0, rcyc = 0, rsp_hi = 0;
    bit aw_done = 0, ar_done = 0, r_exit = 0, got = 0, early_w = 0, acc = 0;
    cmd_write = v.wr; cmd_id = ID_W'(v.id); cmd_addr = v.addr; cmd_len = 8'(v.len); cmd_valid = 1;
    for (int cyc = 0; cyc < 1200 && !got; cyc++) begin
      awready  = (axw >= v.aw_wait);
      arready  = (axw >= v.aw_wait);
      wready   = v.wtoggle ? (cyc % 2 == 1) : 1'b1;
      wd_valid = v.wr && (wbeat <= v.len);
      wd_data  = pat(wbeat);
      wd_strb  = 4'(wbeat) ^ 4'hF;
      bvalid   = aw_done && (wbeat > v.len);
      bid      = ID_W'((v.inj_beat == 0) ? v.inj_id : v.id);
      bresp    = 2'((v.inj_beat == 0) ? v.inj_resp : 0);
      rvalid   = ar_done && !r_exit;
      rid      = ID_W'((rbeat == v.inj_beat) ? v.inj_id : v.id);
      rresp    = 2'((rbeat == v.inj_beat) ? v.inj_resp : 0);
      rlast    = (rbeat == v.rlast_at);
      rdata    = pat(rbeat);
      rd_ready = (rcyc >= v.rd_wait);
      rsp_ready = (rsp_hi >= v.rsp_wait);
      #1;
      if (cmd_valid && cmd_ready) acc = 1;
      if (wvalid && !aw_done) early_w = 1;
      if (wvalid && wready) begin
        chk("wdata", wdata, pat(wbeat));
        chk("wstrb", 32'(wstrb), 32'(4'(wbeat) ^ 4'hF));
        chk("wlast", 32'(wlast), 32'(wbeat == v.len));
        wbeat++;
      end
      if (ar_done && !r_exit) chk("rready", 32'(rready), 32'(rd_ready));
      if (rd_valid && rd_ready) begin
        chk("rd_data", rd_data, pat(rbeat));
        chk("rd_last", 32'(rd_last), 32'(rbeat == v.rlast_at));
        if (rbeat == v.rlast_at || rbeat == v.len) r_exit = 1;
        rbeat++;
      end
      if (ar_done) rcyc++;
      if (rsp_valid) begin
        rsp_hi++;
        if (rsp_ready) begin
          chk("rsp_resp", 32'(rsp_resp), 32'(v.exp_resp));
          chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
          chk("rsp_write", 32'(rsp_write), 32'(v.wr));
          got = 1;
        end
      end
      if (awvalid) begin
        chk("awaddr", awaddr, v.addr);
        chk("awid", 32'(awid), 32'(v.id));
        chk("awlen", 32'(awlen), 32'(v.len));
        axw++;
        if (awready) begin axn++; aw_done = 1; end
      end
      if (arvalid) begin
        chk("araddr", araddr, v.addr);
        chk("arid", 32'(arid), 32'(v.id));
        chk("arsize", 32'(arsize), 32'd2);
        axw++;
        if (arready) begin axn++; ar_done = 1; end
      end
      tick();
      if (acc) cmd_valid = 0;
    end
    if (!got) chk("timeout", 0, 1);
    chk("beats", v.wr ? wbeat : rbeat, v.exp_beats);
    chk("early_wvalid", 32'(early_w), 0);
    chk("addr_handshakes", axn, (v.exp_beats > 0) ? 1 : 0);
    chk("rsp_hold_cycles", rsp_hi, v.rsp_wait + 1);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rstn = 0;
    tick(); tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_valids", 32'({awvalid, wvalid, arvalid, rsp_valid, rd_valid}), 0);
    chk("rst_readies", 32'({bready, rready, wd_ready}), 0);
    chk("rst_awaddr", awaddr, 0);
    rstn = 1;
    tick();
    chk("idle_cmd_ready", 32'(cmd_ready), 1);

    //        wr id addr           len inj rsp iid rl  aww tg rdw rsw  beats resp err
    vt.push_back('{1, 5,  32'h2000, 0,   0,  0, 5,  0,   0, 0, 0, 0,  1,   0, 0});
    vt.push_back('{0, 3,  32'h2100, 3,   255,0, 3,  3,   0, 0, 0, 0,  4,   0, 0});
    vt.push_back('{0, 3,  32'h2200, 1,   1,  2, 4,  1,   0, 0, 0, 0,  2,   2, 1});
    vt.push_back('{1, 7,  32'h2300, 3,   255,0, 7,  0,   5, 1, 0, 2,  4,   0, 0});
    vt.push_back('{0, 3,  32'h2400, 3,   255,0, 3,  3,   0, 0, 3, 0,  4,   0, 0});
    vt.push_back('{1, 9,  32'h2500, 2,   0,  2, 9,  0,   0, 0, 0, 0,  3,   2, 0});
    vt.push_back('{1, 9,  32'h2500, 1,   0,  0, 8,  0,   0, 0, 0, 0,  2,   0, 1});
    vt.push_back('{0, 12, 32'h2600, 3,   255,0, 12, 1,   0, 0, 0, 0,  2,   0, 1});
    vt.push_back('{0, 12, 32'h2600, 1,   255,0, 12, 5,   0, 0, 0, 0,  2,   0, 1});
    vt.push_back('{0, 1,  32'h2700, 2,   0,  3, 1,  2,   2, 0, 0, 0,  3,   3, 0});
    vt.push_back('{0, 63, 32'h2000, 255, 255,0, 63, 255, 0, 0, 0, 0,  256, 0, 0});
    vt.push_back('{1, 2,  32'h2000, 255, 255,0, 2,  0,   0, 1, 0, 1,  256, 0, 0});
`ifdef AXI_MST_ADDR_CHECK_EN
    vt.push_back('{1, 4,  32'h2FFC, 1,   255,0, 4,  0,   0, 0, 0, 0,  0,   3, 0});
    vt.push_back('{1, 4,  32'h2FF8, 1,   255,0, 4,  0,   0, 0, 0, 0,  2,   0, 0});
`endif
    foreach (vt[i]) begin
      cur = i;
      run_vec(vt[i]);
    end

    // Minimum-latency single-beat write against an always-ready slave.
    cur = 100;
    cmd_write = 1; cmd_id = 6'd5; cmd_addr = 32'h2000; cmd_len = 8'd0; cmd_valid = 1;
    wd_valid = 1; wd_data = 32'hDEADBEEF; wd_strb = 4'hF;
    awready = 1; wready = 1; bvalid = 1; bid = 6'd5; bresp = 2'b00; rsp_ready = 1;
    #1;
    chk("T0_cmd_ready", 32'(cmd_ready), 1);
    chk("T0_awvalid", 32'(awvalid), 0);
    tick(); cmd_valid = 0; #1;
    chk("T1_awvalid", 32'(awvalid), 1);
    chk("T1_awsize", 32'(awsize), 2);
    chk("T1_awburst", 32'(awburst), 1);
    chk("T1_wvalid", 32'(wvalid), 0);
    tick();
    chk("T2_wvalid", 32'(wvalid), 1);
    chk("T2_wlast", 32'(wlast), 1);
    chk("T2_wdata", wdata, 32'hDEADBEEF);
    tick();
    chk("T3_bready", 32'(bready), 1);
    chk("T3_rsp_valid", 32'(rsp_valid), 0);
    tick();
    chk("T4_rsp_valid", 32'(rsp_valid), 1);
    chk("T4_rsp_write", 32'(rsp_write), 1);
    tick();
    chk("T5_cmd_ready", 32'(cmd_ready), 1);
    idle_inputs();

    // Reset in the middle of a read burst: no completion, back to idle.
    cur = 101;
    cmd_write = 0; cmd_id = 6'd3; cmd_addr = 32'h2100; cmd_len = 8'd3; cmd_valid = 1;
    arready = 1; rvalid = 1; rid = 6'd3; rdata = 32'h1234; rd_ready = 1; rsp_ready = 1;
    tick(); cmd_valid = 0;
    tick(); #1;
    chk("mid_rd_valid", 32'(rd_valid), 1);
    tick();
    rstn = 0;
    tick();
    chk("rstmid_valids", 32'({awvalid, wvalid, arvalid, rd_valid, rsp_valid}), 0);
    chk("rstmid_readies", 32'({rready, bready, cmd_ready}), 0);
    rstn = 1; idle_inputs();
    tick();
    chk("post_rst_cmd_ready", 32'(cmd_ready), 1);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 0);

    cur = 102;
    run_vec(vt[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
